pdm_demod: RTL and testbench
============================

PDM_DEMOD -- requirements
Module: pdm_demod

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per mic_clk half-period; legal values 3..255.
REQ-002 SHALL have parameter DECIMATION, default 64: PDM bits per output sample; power of two, 2..4096.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: demodulator enable.
REQ-006 SHALL have port mic_clk, output, 1 bit: clock driven to the PDM source, driven from a flop.
REQ-007 SHALL have port pdm_in, input, 1 bit: asynchronous PDM bitstream from the source.
REQ-008 SHALL have port sample, output, 12 bits: demodulated level, 0..4095.
REQ-009 SHALL have port sample_valid, output, 1 bit: sample holds an undelivered value.
REQ-010 SHALL have port sample_ready, input, 1 bit: consumer accepts sample this cycle.

Function
REQ-011 SHALL pass pdm_in through a two-flop synchronizer before any use.
REQ-012 SHALL run a divider counter 0..CLK_DIV-1 while not IDLE and toggle mic_clk when the counter equals CLK_DIV-1; mic_clk period = 2*CLK_DIV clk.
REQ-013 SHALL capture the synchronized bit in the cycle mic_clk toggles 1->0: one bit per mic_clk period.
REQ-014 SHALL count captured ones in an accumulator of width log2(DECIMATION)+1, plus a bit counter 0..DECIMATION-1.
REQ-015 SHALL close a window on the DECIMATION-th captured bit, result = ones count including that bit; accumulator and bit counter restart at 0 the next capture with no bit lost.
REQ-016 SHALL form the result as count << (12 - log2(DECIMATION)), saturated to 4095; when DECIMATION > 4096/2 the shift is replaced by count scaled to 12 bits, saturated.
REQ-017 SHALL implement states IDLE, WARMUP, RUN: IDLE->WARMUP when en=1; WARMUP->RUN at first window close; any state->IDLE when en=0.
REQ-018 SHALL, in IDLE, hold mic_clk=0 and clear divider, accumulator, bit counter and synchronizer; the output register and sample_valid are unaffected.
REQ-019 SHALL discard the window closed in WARMUP (source start-up); only windows closed in RUN produce samples.
REQ-020 SHALL, on a RUN window close with sample_valid=0 or sample_ready=1 in the same cycle, load sample and set sample_valid=1 the next cycle (latency 1 clk from close).
REQ-021 SHALL clear sample_valid the cycle after sample_valid&sample_ready unless REQ-020 reloads in the same cycle.
REQ-022 SHALL, on a window close with sample_valid=1 and sample_ready=0, drop the new result and keep sample unchanged (overrun).
REQ-023 SHALL keep sample stable while sample_valid=1 and sample_ready=0.

Reset
REQ-024 SHALL on rst=1 immediately force state IDLE, mic_clk=0, sample=0, sample_valid=0, all counters and synchronizer flops 0, independent of clk.
REQ-025 SHALL after rst deassertion with en=1 enter WARMUP on the first clk edge; rst mid-window discards that partial window.

Configuration
REQ-026 SHALL, with macro PDM_DEMOD_OVERRUN_EN defined, add output overrun (1 bit), reset 0, set sticky on each REQ-022 event and cleared only by rst or en=0.
REQ-027 SHALL, without PDM_DEMOD_OVERRUN_EN, omit the overrun port and its flop; REQ-022 drop behaviour unchanged.

Verification (CLK_DIV=4, DECIMATION=64: window 512 clk)
REQ-028 SHALL cover: pdm_in=1 constant, ready=1 -> first sample_valid about 1024 clk after en, sample=4095, then every 512 clk.
REQ-029 SHALL cover: pdm_in=0 constant -> sample=0; pdm_in toggling each mic_clk period -> sample=2048.
REQ-030 SHALL cover: ready=0 across two RUN closes with ones density 25% then 75% -> sample stays 1024, second result dropped, overrun=1 (macro on).
REQ-031 SHALL cover: ready pulsed in same cycle as window close -> new sample loaded, sample_valid stays 1, no overrun.
REQ-032 SHALL cover: rst asserted mid-window between clk edges -> outputs 0 immediately; after release the next sample appears only after a full WARMUP window plus a RUN window.
REQ-033 SHALL cover: en dropped mid-window -> mic_clk=0 within 1 clk, held sample_valid/sample preserved until accepted.

Source files
------------

// File: rtl/pdm_demod.sv
`timescale 1ns/1ps
// pdm_demod: PDM microphone front end. Generates mic_clk for the source,
// captures one PDM bit per mic_clk period, counts ones over DECIMATION bits
// and delivers the 12-bit level through a valid/ready output register.
//
// Parameters
//   CLK_DIV     clk cycles per mic_clk half-period (3..255)
//   DECIMATION  PDM bits per output sample (power of two, 2..4096)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   en            demodulator enable; en=0 returns the front end to IDLE
//   mic_clk       clock to the PDM source (registered)
//   pdm_in        asynchronous PDM bitstream
//   sample        demodulated level 0..4095
//   sample_valid  sample holds an undelivered value
//   sample_ready  consumer accepts sample this cycle
//   overrun       (only with PDM_DEMOD_OVERRUN_EN) sticky flag: a result was
//                 dropped because the previous sample was still undelivered
//
// Optional feature macro: PDM_DEMOD_OVERRUN_EN adds the overrun output.
//
// Output handshake: a sample transfers on every clk edge where sample_valid
// and sample_ready are both 1. sample is stable while sample_valid=1 and
// sample_ready=0. A new result loads when the register is empty or is being
// drained in the same cycle; otherwise the new result is dropped (overrun).
module pdm_demod #(
    parameter int CLK_DIV    = 4,
    parameter int DECIMATION = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        mic_clk,
    input  logic        pdm_in,
    output logic [11:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready
`ifdef PDM_DEMOD_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam int LOG2_DEC = $clog2(DECIMATION);
    localparam int ACC_W    = LOG2_DEC + 1;
    localparam int BIT_W    = LOG2_DEC;
    localparam int DIV_W    = $clog2(CLK_DIV);
    // Above 2048 bits per window the count already spans 12 bits, so no shift.
    localparam int SHIFT    = (DECIMATION > 2048) ? 0 : (12 - LOG2_DEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state;
    logic               sync_q1;
    logic               sync_q2;
    logic [DIV_W-1:0]   div_cnt;
    logic [ACC_W-1:0]   acc;
    logic [BIT_W-1:0]   bit_cnt;

    logic               div_last;
    logic               capture;
    logic               window_close;
    logic               run_close;
    logic [ACC_W-1:0]   win_count;
    logic [23:0]        scaled;
    logic [11:0]        result;

    assign div_last     = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Capture in the cycle mic_clk is about to fall (1 -> 0).
    assign capture      = (state != IDLE) && div_last && mic_clk;
    assign window_close = capture && (bit_cnt == BIT_W'(DECIMATION - 1));
    assign run_close    = en && (state == RUN) && window_close;
    // The closing bit itself belongs to the window being closed.
    assign win_count    = acc + ACC_W'(sync_q2);
    assign scaled       = 24'(win_count) << SHIFT;
    assign result       = (scaled > 24'd4095) ? 12'hFFF : scaled[11:0];

    // Front end: state machine, synchronizer, divider and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            div_cnt <= '0;
            mic_clk <= 1'b0;
            acc     <= '0;
            bit_cnt <= '0;
        end else if (!en || state == IDLE) begin
            // Idle (or leaving for it): everything upstream of the output
            // register is cleared so the next start-up begins from scratch.
            state   <= en ? WARMUP : IDLE;
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            div_cnt <= '0;
            mic_clk <= 1'b0;
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            sync_q1 <= pdm_in;
            sync_q2 <= sync_q1;
            if (div_last) begin
                div_cnt <= '0;
                mic_clk <= ~mic_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (capture) begin
                if (window_close) begin
                    acc     <= '0;
                    bit_cnt <= '0;
                    // The start-up window is thrown away; later ones are real.
                    if (state == WARMUP) begin
                        state <= RUN;
                    end
                end else begin
                    acc     <= win_count;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Output register: survives en=0 so a held sample can still be taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (run_close && (!sample_valid || sample_ready)) begin
            sample       <= result;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

`ifdef PDM_DEMOD_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (!en) begin
            overrun <= 1'b0;
        end else if (run_close && sample_valid && !sample_ready) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_demod.sv
`timescale 1ns/1ps
// Bench for pdm_demod with CLK_DIV=4, DECIMATION=64 (window = 512 clk,
// first sample 1024 clk after enable: one warm-up window plus one run window).
module tb_pdm_demod;

    localparam int CLK_DIV    = 4;
    localparam int DECIMATION = 64;
    localparam int WIN        = 2 * CLK_DIV * DECIMATION;

    // pdm_mode encoding for the stimulus driver
    localparam int M_ZERO = 0;
    localparam int M_ONE  = 1;
    localparam int M_ALT  = 2;
    localparam int M_D25  = 3;
    localparam int M_D75  = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mic_clk;
    logic        pdm_in;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
`ifdef PDM_DEMOD_OVERRUN_EN
    logic        overrun;
`endif

    int errors = 0;
    int checks = 0;
    int pdm_mode = M_ZERO;
    int phase = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        string       name;
        int          mode;
        logic [11:0] exp_sample;
    } vec_t;
    vec_t vecs[5];

    pdm_demod #(
        .CLK_DIV    (CLK_DIV),
        .DECIMATION (DECIMATION)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mic_clk      (mic_clk),
        .pdm_in       (pdm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
`ifdef PDM_DEMOD_OVERRUN_EN
        ,
        .overrun      (overrun)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PDM source model: one new bit per mic_clk period.
    initial begin
        pdm_in = 1'b0;
        forever begin
            @(posedge mic_clk);
            phase = (phase + 1) % 4;
            case (pdm_mode)
                M_ZERO:  pdm_in = 1'b0;
                M_ONE:   pdm_in = 1'b1;
                M_ALT:   pdm_in = ~pdm_in;
                M_D25:   pdm_in = (phase == 0);
                M_D75:   pdm_in = (phase != 0);
                default: pdm_in = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count clk edges until sample_valid rises; -1 if the budget expires.
    task automatic wait_rise(input int budget, output int cycles);
        logic prev;
        logic found;
        prev   = sample_valid;
        found  = 1'b0;
        cycles = 0;
        while (cycles < budget && !found) begin
            @(posedge clk);
            #1;
            cycles++;
            if (sample_valid && !prev) found = 1'b1;
            prev = sample_valid;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_rise: no sample_valid rise within %0d cycles", budget);
            cycles = -1;
        end
    endtask

    // Wait until mic_clk reads 1; failure counted if it never does.
    task automatic wait_mic_high(input int budget);
        int n;
        n = 0;
        while (!mic_clk && n < budget) begin
            tick(1);
            n++;
        end
        if (!mic_clk) begin
            checks++;
            errors++;
            $display("FAIL wait_mic_high: mic_clk stayed 0 for %0d cycles", budget);
        end
    endtask

    // Disable, take any held sample, leave ready low.
    task automatic drain();
        en = 1'b0;
        sample_ready = 1'b1;
        tick(2);
        sample_ready = 1'b0;
    endtask

    // Enable and step past the IDLE->WARMUP edge (edge 0).
    task automatic start(input int mode);
        pdm_mode = mode;
        en = 1'b1;
        tick(1);
    endtask

    initial begin
        int lat;
        int n;

        vecs[0] = '{name: "ones",  mode: M_ONE,  exp_sample: 12'd4095};
        vecs[1] = '{name: "zeros", mode: M_ZERO, exp_sample: 12'd0};
        vecs[2] = '{name: "alt",   mode: M_ALT,  exp_sample: 12'd2048};
        vecs[3] = '{name: "d25",   mode: M_D25,  exp_sample: 12'd1024};
        vecs[4] = '{name: "d75",   mode: M_D75,  exp_sample: 12'd3072};

        // reset state
        rst = 1'b1;
        en = 1'b0;
        sample_ready = 1'b0;
        tick(3);
        check("rst_mic_clk", int'(mic_clk), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
`ifdef PDM_DEMOD_OVERRUN_EN
        check("rst_overrun", int'(overrun), 0);
`endif
        rst = 1'b0;
        tick(2);
        check("idle_mic_clk", int'(mic_clk), 0);

        // table-driven streaming with ready held high
        for (int i = 0; i < 5; i++) begin
            drain();
            sample_ready = 1'b1;
            exp_q.push_back(vecs[i].exp_sample);
            exp_q.push_back(vecs[i].exp_sample);
            start(vecs[i].mode);
            wait_rise(2 * WIN + 50, lat);
            check({vecs[i].name, "_first_latency"}, lat, 2 * WIN);
            check({vecs[i].name, "_first_sample"}, int'(sample), int'(exp_q.pop_front()));
            wait_rise(WIN + 50, lat);
            check({vecs[i].name, "_period"}, lat, WIN);
            check({vecs[i].name, "_second_sample"}, int'(sample), int'(exp_q.pop_front()));
        end

        // mic_clk period while running
        wait_mic_high(20);
        n = 0;
        while (mic_clk && n < 20) begin tick(1); n++; end
        while (!mic_clk && n < 40) begin tick(1); n++; end
        n = 0;
        while (mic_clk && n < 20) begin tick(1); n++; end
        while (!mic_clk && n < 40) begin tick(1); n++; end
        check("mic_clk_period", n, 2 * CLK_DIV);

        // overrun: 25% window held, following 75% window dropped
        drain();
        start(M_D25);
        wait_rise(2 * WIN + 50, lat);
        check("ovr_first_sample", int'(sample), 1024);
        pdm_mode = M_D75;
        tick(WIN + 88);
        check("ovr_held_valid", int'(sample_valid), 1);
        check("ovr_held_sample", int'(sample), 1024);
`ifdef PDM_DEMOD_OVERRUN_EN
        check("ovr_flag_set", int'(overrun), 1);
`endif
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        check("ovr_accept_clears_valid", int'(sample_valid), 0);
        wait_rise(WIN + 50, lat);
        check("ovr_next_sample", int'(sample), 3072);
`ifdef PDM_DEMOD_OVERRUN_EN
        check("ovr_flag_sticky", int'(overrun), 1);
`endif

        // ready pulsed in the same cycle as a window close
        drain();
        start(M_ALT);
        wait_rise(2 * WIN + 50, lat);
        check("pulse_first_sample", int'(sample), 2048);
        pdm_mode = M_ONE;
        tick(WIN - 1);
        check("pulse_pre_valid", int'(sample_valid), 1);
        check("pulse_pre_sample", int'(sample), 2048);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        check("pulse_valid_kept", int'(sample_valid), 1);
        check("pulse_new_sample", int'(sample), 4095);
`ifdef PDM_DEMOD_OVERRUN_EN
        check("pulse_no_overrun", int'(overrun), 0);
`endif

        // en dropped mid-window with a sample held
        tick(100);
        wait_mic_high(20);
        en = 1'b0;
        tick(1);
        check("endrop_mic_clk", int'(mic_clk), 0);
        tick(20);
        check("endrop_valid_held", int'(sample_valid), 1);
        check("endrop_sample_held", int'(sample), 4095);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        check("endrop_accept", int'(sample_valid), 0);

        // rst asserted between clk edges, mid-window
        start(M_ONE);
        wait_rise(2 * WIN + 50, lat);
        check("rstmid_pre_sample", int'(sample), 4095);
        tick(100);
        wait_mic_high(20);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_mic_clk", int'(mic_clk), 0);
        check("rstmid_sample", int'(sample), 0);
        check("rstmid_valid", int'(sample_valid), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        wait_rise(2 * WIN + 50, lat);
        check("rstmid_restart_latency", lat, 2 * WIN);
        check("rstmid_restart_sample", int'(sample), 4095);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
